// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control bundle layout and ALU encodings.
package id_ex_stage_pkg;

    localparam int unsigned CTRL_W = 16;

    // ALU first operand select
    typedef enum logic [1:0] {
        ALU_SRC1_RS1  = 2'b00,
        ALU_SRC1_PC   = 2'b01,
        ALU_SRC1_ZERO = 2'b10
    } aluSrc1_e;

    // ALU second operand select
    typedef enum logic [1:0] {
        ALU_SRC2_RS2  = 2'b00,
        ALU_SRC2_IMM  = 2'b01,
        ALU_SRC2_FOUR = 2'b10
    } aluSrc2_e;

    // ALU operation codes
    typedef enum logic [2:0] {
        ALU_OP_ADD = 3'd0,
        ALU_OP_SUB = 3'd1,
        ALU_OP_AND = 3'd2,
        ALU_OP_OR  = 3'd3,
        ALU_OP_XOR = 3'd4,
        ALU_OP_SLT = 3'd5,
        ALU_OP_SHL = 3'd6,
        ALU_OP_SHR = 3'd7
    } aluOperation_e;

    // Decoded control bundle, padded to 16 bits with zeros at the top.
    typedef struct packed {
        logic [2:0]    pad;
        logic          pcUpdate;
        logic          memoryReadEnable;
        logic          memoryWriteEnable;
        logic          registerWriteEnable;
        aluSrc1_e      aluSrc1;
        aluSrc2_e      aluSrc2;
        aluOperation_e aluOperation;
        logic          pcAdderSrc;
        logic          writeBackFromAluOrMemory;
    } controlBundle;

    localparam controlBundle CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detector.sv
// Load-use hazard compare: ID sources against the load currently sitting in EX.
module load_use_detector
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  exValid,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUsesRs1,
    input  logic                  idUsesRs2,
    output logic                  hazardStall
);

    logic w_rs1_match;
    logic w_rs2_match;

    // x0 is never written, so a load targeting it cannot create a dependency
    always_comb begin
        w_rs1_match = idUsesRs1 && (idRs1 == exRd);
        w_rs2_match = idUsesRs2 && (idRs2 == exRd);
        hazardStall = exValid && exMemRead && (exRd != '0) &&
                      (w_rs1_match || w_rs2_match) && idValid;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, stall hold and flush.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_COUNT_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  stallIn,
    input  logic                  flushIn,
    input  logic                  idValid,
    input  logic [CTRL_W-1:0]     idCtrl,
    input  logic [XLEN-1:0]       idPc,
    input  logic [XLEN-1:0]       idRs1Data,
    input  logic [XLEN-1:0]       idRs2Data,
    input  logic [XLEN-1:0]       idImm,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic [REG_ADDR_W-1:0] idRd,
    input  logic                  idUsesRs1,
    input  logic                  idUsesRs2,
    input  logic [2:0]            idFunct3,
    input  logic                  idFunct7b5,
    output logic                  exValid,
    output logic [CTRL_W-1:0]     exCtrl,
    output logic [XLEN-1:0]       exPc,
    output logic [XLEN-1:0]       exRs1Data,
    output logic [XLEN-1:0]       exRs2Data,
    output logic [XLEN-1:0]       exImm,
    output logic [REG_ADDR_W-1:0] exRs1,
    output logic [REG_ADDR_W-1:0] exRs2,
    output logic [REG_ADDR_W-1:0] exRd,
    output logic [2:0]            exFunct3,
    output logic                  exFunct7b5,
`ifdef ID_EX_BUBBLE_COUNT_EN
    output logic [31:0]           bubbleCount,
`endif
    output logic                  hazardStall
);

    logic                  r_valid,   w_valid_d;
    controlBundle          r_ctrl,    w_ctrl_d;
    logic [XLEN-1:0]       r_pc,      w_pc_d;
    logic [XLEN-1:0]       r_rs1_data, w_rs1_data_d;
    logic [XLEN-1:0]       r_rs2_data, w_rs2_data_d;
    logic [XLEN-1:0]       r_imm,     w_imm_d;
    logic [REG_ADDR_W-1:0] r_rs1,     w_rs1_d;
    logic [REG_ADDR_W-1:0] r_rs2,     w_rs2_d;
    logic [REG_ADDR_W-1:0] r_rd,      w_rd_d;
    logic [2:0]            r_funct3,  w_funct3_d;
    logic                  r_funct7b5, w_funct7b5_d;

    logic w_hazard;
    logic w_bubble;

    load_use_detector #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detector (
        .exValid     (r_valid),
        .exMemRead   (r_ctrl.memoryReadEnable),
        .exRd        (r_rd),
        .idValid     (idValid),
        .idRs1       (idRs1),
        .idRs2       (idRs2),
        .idUsesRs1   (idUsesRs1),
        .idUsesRs2   (idUsesRs2),
        .hazardStall (w_hazard)
    );

    // Flush beats stall; a hazard bubble only happens when not stalled
    assign w_bubble = flushIn || (!stallIn && w_hazard);

    // Next-state: flush/hazard bubble, stall hold, or load from ID
    always_comb begin
        w_valid_d    = r_valid;
        w_ctrl_d     = r_ctrl;
        w_pc_d       = r_pc;
        w_rs1_data_d = r_rs1_data;
        w_rs2_data_d = r_rs2_data;
        w_imm_d      = r_imm;
        w_rs1_d      = r_rs1;
        w_rs2_d      = r_rs2;
        w_rd_d       = r_rd;
        w_funct3_d   = r_funct3;
        w_funct7b5_d = r_funct7b5;
        if (w_bubble) begin
            w_valid_d    = 1'b0;
            w_ctrl_d     = CTRL_BUBBLE;
            w_pc_d       = '0;
            w_rs1_data_d = '0;
            w_rs2_data_d = '0;
            w_imm_d      = '0;
            w_rs1_d      = '0;
            w_rs2_d      = '0;
            w_rd_d       = '0;
            w_funct3_d   = '0;
            w_funct7b5_d = 1'b0;
        end else if (!stallIn) begin
            w_valid_d    = idValid;
            // An invalid slot must never carry write enables or pcUpdate
            w_ctrl_d     = idValid ? controlBundle'(idCtrl) : CTRL_BUBBLE;
            w_pc_d       = idPc;
            w_rs1_data_d = idRs1Data;
            w_rs2_data_d = idRs2Data;
            w_imm_d      = idImm;
            w_rs1_d      = idRs1;
            w_rs2_d      = idRs2;
            w_rd_d       = idRd;
            w_funct3_d   = idFunct3;
            w_funct7b5_d = idFunct7b5;
        end
    end

    // EX-stage register bank
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_valid    <= 1'b0;
            r_ctrl     <= CTRL_BUBBLE;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
        end else begin
            r_valid    <= w_valid_d;
            r_ctrl     <= w_ctrl_d;
            r_pc       <= w_pc_d;
            r_rs1_data <= w_rs1_data_d;
            r_rs2_data <= w_rs2_data_d;
            r_imm      <= w_imm_d;
            r_rs1      <= w_rs1_d;
            r_rs2      <= w_rs2_d;
            r_rd       <= w_rd_d;
            r_funct3   <= w_funct3_d;
            r_funct7b5 <= w_funct7b5_d;
        end
    end

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] r_bubble_count;
    logic [31:0] w_bubble_count_d;

    // Saturating count of inserted hazard/flush bubbles
    always_comb begin
        w_bubble_count_d = r_bubble_count;
        if (w_bubble && (r_bubble_count != 32'hFFFF_FFFF)) begin
            w_bubble_count_d = r_bubble_count + 32'd1;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_bubble_count <= '0;
        end else begin
            r_bubble_count <= w_bubble_count_d;
        end
    end

    assign bubbleCount = r_bubble_count;
`endif

    assign exValid     = r_valid;
    assign exCtrl      = r_ctrl;
    assign exPc        = r_pc;
    assign exRs1Data   = r_rs1_data;
    assign exRs2Data   = r_rs2_data;
    assign exImm       = r_imm;
    assign exRs1       = r_rs1;
    assign exRs2       = r_rs2;
    assign exRd        = r_rd;
    assign exFunct3    = r_funct3;
    assign exFunct7b5  = r_funct7b5;
    assign hazardStall = w_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use bubbles, stall hold, flush, invalid ID.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk;
    logic        resetN;
    logic        stallIn;
    logic        flushIn;
    logic        idValid;
    logic [15:0] idCtrl;
    logic [31:0] idPc, idRs1Data, idRs2Data, idImm;
    logic [4:0]  idRs1, idRs2, idRd;
    logic        idUsesRs1, idUsesRs2;
    logic [2:0]  idFunct3;
    logic        idFunct7b5;
    logic        exValid;
    logic [15:0] exCtrl;
    logic [31:0] exPc, exRs1Data, exRs2Data, exImm;
    logic [4:0]  exRs1, exRs2, exRd;
    logic [2:0]  exFunct3;
    logic        exFunct7b5;
    logic        hazardStall;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubbleCount;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_bubbles = 0;

    controlBundle cb_alu, cb_load;
    logic [15:0]  ctrl_alu, ctrl_load;

    id_ex_stage dut (
        .clk         (clk),
        .resetN      (resetN),
        .stallIn     (stallIn),
        .flushIn     (flushIn),
        .idValid     (idValid),
        .idCtrl      (idCtrl),
        .idPc        (idPc),
        .idRs1Data   (idRs1Data),
        .idRs2Data   (idRs2Data),
        .idImm       (idImm),
        .idRs1       (idRs1),
        .idRs2       (idRs2),
        .idRd        (idRd),
        .idUsesRs1   (idUsesRs1),
        .idUsesRs2   (idUsesRs2),
        .idFunct3    (idFunct3),
        .idFunct7b5  (idFunct7b5),
        .exValid     (exValid),
        .exCtrl      (exCtrl),
        .exPc        (exPc),
        .exRs1Data   (exRs1Data),
        .exRs2Data   (exRs2Data),
        .exImm       (exImm),
        .exRs1       (exRs1),
        .exRs2       (exRs2),
        .exRd        (exRd),
        .exFunct3    (exFunct3),
        .exFunct7b5  (exFunct7b5),
`ifdef ID_EX_BUBBLE_COUNT_EN
        .bubbleCount (bubbleCount),
`endif
        .hazardStall (hazardStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an ID instruction; data fields derive from pc so loads are traceable
    task automatic set_id(input logic v, input logic [15:0] c, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2);
        idValid    = v;
        idCtrl     = c;
        idPc       = pc;
        idRs1Data  = pc ^ 32'hA5A5_0000;
        idRs2Data  = pc ^ 32'h5A5A_0000;
        idImm      = pc + 32'h0000_1000;
        idRs1      = rs1;
        idRs2      = rs2;
        idRd       = rd;
        idUsesRs1  = u1;
        idUsesRs2  = u2;
        idFunct3   = pc[4:2];
        idFunct7b5 = pc[2];
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 64'(exValid), 64'd0);
        chk({tag, "_ctrl"}, 64'(exCtrl), 64'd0);
        chk({tag, "_pc"}, 64'(exPc), 64'd0);
        chk({tag, "_rd"}, 64'(exRd), 64'd0);
    endtask

    initial begin
        cb_alu  = CTRL_BUBBLE;
        cb_alu.registerWriteEnable = 1'b1;
        cb_alu.aluSrc1      = ALU_SRC1_RS1;
        cb_alu.aluSrc2      = ALU_SRC2_RS2;
        cb_alu.aluOperation = ALU_OP_SUB;
        ctrl_alu = cb_alu;
        cb_load = CTRL_BUBBLE;
        cb_load.memoryReadEnable    = 1'b1;
        cb_load.registerWriteEnable = 1'b1;
        cb_load.aluSrc2             = ALU_SRC2_IMM;
        cb_load.aluOperation        = ALU_OP_ADD;
        cb_load.writeBackFromAluOrMemory = 1'b1;
        ctrl_load = cb_load;

        // Reset with random inputs
        resetN  = 1'b0;
        stallIn = 1'b0;
        flushIn = 1'b0;
        set_id(1'b1, 16'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
               1'b1, 1'b1);
        tick();
        tick();
        chk("rst_valid", 64'(exValid), 64'd0);
        chk("rst_ctrl", 64'(exCtrl), 64'd0);
        chk("rst_pc", 64'(exPc), 64'd0);
        chk("rst_rs1data", 64'(exRs1Data), 64'd0);
        chk("rst_imm", 64'(exImm), 64'd0);
        chk("rst_rd", 64'(exRd), 64'd0);
        chk("rst_hazard", 64'(hazardStall), 64'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk("rst_bubbles", 64'(bubbleCount), 64'd0);
`endif

        // First load after release
        resetN = 1'b1;
        set_id(1'b1, ctrl_alu, 32'h40, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        tick();
        chk("first_rd", 64'(exRd), 64'd5);
        chk("first_valid", 64'(exValid), 64'd1);
        chk("first_pc", 64'(exPc), 64'h40);
        chk("first_ctrl", 64'(exCtrl), 64'(ctrl_alu));
        chk("first_rs1data", 64'(exRs1Data), 64'h A5A5_0040);
        chk("first_rs2data", 64'(exRs2Data), 64'h 5A5A_0040);
        chk("first_imm", 64'(exImm), 64'h1040);
        chk("first_rs12", 64'({exRs1, exRs2}), 64'({5'd1, 5'd2}));
        chk("first_funct", 64'({exFunct3, exFunct7b5}), 64'({3'd0, 1'b0}));

        // Load-use on rs1
        set_id(1'b1, ctrl_load, 32'h44, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0);
        #1 chk("lu_pre_hazard", 64'(hazardStall), 64'd0);
        tick();
        chk("lu_load_ctrl", 64'(exCtrl), 64'(ctrl_load));
        set_id(1'b1, ctrl_alu, 32'h48, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
        #1 chk("lu_hazard", 64'(hazardStall), 64'd1);
        tick();
        exp_bubbles++;
        chk_bubble("lu_bubble");
        chk("lu_hazard_clear", 64'(hazardStall), 64'd0);
        tick();
        chk("lu_after_pc", 64'(exPc), 64'h48);
        chk("lu_after_valid", 64'(exValid), 64'd1);
        chk("lu_after_rs1", 64'(exRs1), 64'd3);

        // Load to x0 never stalls
        set_id(1'b1, ctrl_load, 32'h4C, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, ctrl_alu, 32'h50, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1);
        #1 chk("rd0_hazard", 64'(hazardStall), 64'd0);
        tick();
        chk("rd0_pc", 64'(exPc), 64'h50);

        // Matching but unused rs2 never stalls
        set_id(1'b1, ctrl_load, 32'h54, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, ctrl_alu, 32'h58, 5'd7, 5'd3, 5'd8, 1'b1, 1'b0);
        #1 chk("unused_hazard", 64'(hazardStall), 64'd0);
        tick();
        chk("unused_pc", 64'(exPc), 64'h58);

        // Back-to-back dependent loads: one bubble each
        set_id(1'b1, ctrl_load, 32'h5C, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, ctrl_load, 32'h60, 5'd1, 5'd3, 5'd6, 1'b1, 1'b1);
        #1 chk("b2b_hazard1", 64'(hazardStall), 64'd1);
        tick();
        exp_bubbles++;
        chk("b2b_bubble1", 64'(exValid), 64'd0);
        tick();
        chk("b2b_load2_pc", 64'(exPc), 64'h60);
        set_id(1'b1, ctrl_alu, 32'h64, 5'd6, 5'd0, 5'd9, 1'b1, 1'b0);
        #1 chk("b2b_hazard2", 64'(hazardStall), 64'd1);
        tick();
        exp_bubbles++;
        chk_bubble("b2b_bubble2");
        tick();
        chk("b2b_alu_pc", 64'(exPc), 64'h64);

        // Stall hold for 3 cycles while ID changes
        set_id(1'b1, ctrl_alu, 32'h40, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        tick();
        stallIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, ctrl_load, 32'h100 + 32'(i * 4), 5'd2, 5'd3, 5'd10, 1'b1, 1'b1);
            tick();
            chk("stall_pc", 64'(exPc), 64'h40);
            chk("stall_ctrl", 64'(exCtrl), 64'(ctrl_alu));
        end
        stallIn = 1'b0;
        set_id(1'b1, ctrl_alu, 32'h70, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1);
        tick();
        chk("stall_release_pc", 64'(exPc), 64'h70);

        // Hazard raised but stalled: EX holds, no bubble counted
        set_id(1'b1, ctrl_load, 32'h74, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0);
        tick();
        stallIn = 1'b1;
        set_id(1'b1, ctrl_alu, 32'h78, 5'd9, 5'd0, 5'd12, 1'b1, 1'b0);
        #1 chk("stallhz_hazard", 64'(hazardStall), 64'd1);
        tick();
        chk("stallhz_pc", 64'(exPc), 64'h74);
        chk("stallhz_valid", 64'(exValid), 64'd1);
        chk("stallhz_hazard_held", 64'(hazardStall), 64'd1);

        // Flush with stall and hazard both active
        flushIn = 1'b1;
        tick();
        exp_bubbles++;
        chk_bubble("flush");
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk("flush_bubbles", 64'(bubbleCount), 64'(exp_bubbles));
`endif

        // Invalid ID with all control bits set
        flushIn = 1'b0;
        stallIn = 1'b0;
        set_id(1'b0, 16'hFFFF, 32'h80, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1);
        #1 chk("inv_hazard", 64'(hazardStall), 64'd0);
        tick();
        chk("inv_valid", 64'(exValid), 64'd0);
        chk("inv_ctrl", 64'(exCtrl), 64'd0);
        chk("inv_pc", 64'(exPc), 64'h80);
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk("inv_bubbles", 64'(bubbleCount), 64'(exp_bubbles));
`endif

        // Reset asserted mid-stall clears immediately
        set_id(1'b1, ctrl_alu, 32'h84, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
        tick();
        chk("pre_rst_pc", 64'(exPc), 64'h84);
        stallIn = 1'b1;
        #2 resetN = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(exValid), 64'd0);
        chk("mid_rst_pc", 64'(exPc), 64'd0);
        chk("mid_rst_ctrl", 64'(exCtrl), 64'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk("mid_rst_bubbles", 64'(bubbleCount), 64'd0);
`endif
        tick();
        resetN  = 1'b1;
        stallIn = 1'b0;
        set_id(1'b1, ctrl_alu, 32'h90, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        tick();
        chk("post_rst_pc", 64'(exPc), 64'h90);
        chk("post_rst_rd", 64'(exRd), 64'd5);
        chk("post_rst_valid", 64'(exValid), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
